// File: rtl/imem_pkg.sv
// Shared types and address-map constants for the banked instruction memory
// and its boot loader.
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } imem_state_e;

  localparam int IMEM_BANK_ROWS    = 512;
  localparam int IMEM_MAX_WORDS    = 1024;
  localparam int IMEM_BANK_SEL_BIT = 11;
  localparam int IMEM_ROW_LSB      = 2;
  localparam int IMEM_ROW_MSB      = 10;

endpackage

// File: rtl/imem_wr_decode.sv
// Registered write-port stage: turns an accepted word index into the bank
// strobes and shared row address/data of the two instruction-memory banks.
module imem_wr_decode
  import imem_pkg::*;
#(
  parameter int BANK_ROWS = IMEM_BANK_ROWS,
  parameter int ROW_W     = $clog2(BANK_ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_p0,
  input  logic [ROW_W:0]   idx_p0,
  input  logic [31:0]      data_p0,
  output logic             we0,
  output logic             we1,
  output logic [ROW_W-1:0] waddr,
  output logic [31:0]      wdata
);

  // Word index i is byte address 4*i, so the bank and row bits shift down by two.
  localparam int BANK_BIT = IMEM_BANK_SEL_BIT - IMEM_ROW_LSB;
  localparam int ROW_TOP  = IMEM_ROW_MSB - IMEM_ROW_LSB;

  // p0 -> p1: strobes live exactly one cycle; address/data hold between writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we0   <= 1'b0;
      we1   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we0 <= vld_p0 & ~idx_p0[BANK_BIT];
      we1 <= vld_p0 &  idx_p0[BANK_BIT];
      if (vld_p0) begin
        waddr <= idx_p0[ROW_TOP:0];
        wdata <= data_p0;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program image into the two instruction-memory banks,
// verifies the trailing additive checksum and then releases the CPU stall.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int BANK_ROWS = IMEM_BANK_ROWS,
  parameter int MAX_WORDS = IMEM_MAX_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] load_len,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        we0,
  output logic        we1,
  output logic [8:0]  waddr,
  output logic [31:0] wdata,
  output logic        cpu_stall,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [10:0] MAX_LEN = 11'(MAX_WORDS);

  imem_state_e state, state_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic [9:0]  len_m1, len_m1_nxt;
  logic [31:0] acc, acc_nxt;
  logic        accept_p0;
  logic        vld_p0;
  logic        len_ok;

  assign accept_p0 = s_valid & s_ready;
  assign vld_p0    = accept_p0 & (state == ST_LOAD);
  assign len_ok    = (load_len != 11'd0) && (load_len <= MAX_LEN);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    len_m1_nxt = len_m1;
    acc_nxt    = acc;
    case (state)
      ST_LOAD: begin
        if (accept_p0) begin
          acc_nxt = acc + s_data;
          cnt_nxt = cnt + 10'd1;
          if (cnt == len_m1) state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // The trailer only closes the image; it is never forwarded to memory.
        if (accept_p0) state_nxt = (s_data == acc) ? ST_RUN : ST_ERROR;
      end
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          if (len_ok) begin
            state_nxt  = ST_LOAD;
            cnt_nxt    = 10'd0;
            acc_nxt    = 32'd0;
            len_m1_nxt = 10'(load_len - 11'd1);
          end else begin
            state_nxt = ST_ERROR;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track it with no lag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len_m1    <= '0;
      acc       <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      cpu_stall <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      len_m1    <= len_m1_nxt;
      acc       <= acc_nxt;
      s_ready   <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
      busy      <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
      cpu_stall <= (state_nxt != ST_RUN);
      done      <= (state_nxt == ST_RUN);
      err       <= (state_nxt == ST_ERROR);
    end
  end

  imem_wr_decode #(
    .BANK_ROWS (BANK_ROWS)
  ) u_wr_decode (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_p0  (vld_p0),
    .idx_p0  (cnt),
    .data_p0 (s_data),
    .we0     (we0),
    .we1     (we1),
    .waddr   (waddr),
    .wdata   (wdata)
  );

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the banked instruction memory (2 banks x 512 words, bank select = byte-address bit 11, row = bits 10:2).
- Accepts a program image as a valid/ready word stream and writes each word into the correct bank and row.
- Verifies a trailing checksum, then releases the CPU from stall.
- Sits between the host/debug loader interface and the write ports of the two instruction-memory banks, and drives the CPU stall input.

Parameters:
- BANK_ROWS, 512, words per bank; row address width = 9.
- MAX_WORDS, 1024, total image capacity (2 x BANK_ROWS); load_len width = 11.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle load request.
- load_len  in  11  image length in words, sampled when start=1.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word.
- s_ready  out  1  loader can accept a word.
- we0  out  1  bank-0 write strobe.
- we1  out  1  bank-1 write strobe.
- waddr  out  9  row address, shared by both banks.
- wdata  out  32  write data, shared by both banks.
- cpu_stall  out  1  holds CPU PC/fetch.
- busy  out  1  state is LOAD or CHECK.
- done  out  1  image loaded and verified.
- err  out  1  length or checksum error.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; s_ready=0, we0=we1=0, waddr=0, wdata=0, cpu_stall=1, busy=0, done=0, err=0.
  - Word counter cnt=0, checksum acc=0.
  - Reset mid-LOAD/CHECK aborts immediately; no write strobe in the following cycle.
- State set: IDLE, LOAD, CHECK, RUN, ERROR.
- IDLE:
  - start=1 with 1 <= load_len <= 1024: latch len, cnt=0, acc=0, go to LOAD.
  - start=1 with load_len=0 or load_len>1024: go to ERROR.
- LOAD:
  - s_ready=1, busy=1, cpu_stall=1.
  - Handshake: a word is accepted when s_valid & s_ready at the clock edge.
  - On each accept, in the next cycle: wdata=s_data, waddr=cnt[8:0], we0=~cnt[9], we1=cnt[9].
  - Strobes are exactly one cycle wide, at most one per cycle, never both high.
  - acc += s_data modulo 2^32; cnt++.
  - Accepting word number len-1 moves to CHECK.
  - s_valid gaps are allowed; no strobe is issued in gap cycles.
- CHECK:
  - s_ready=1, busy=1; accepts exactly one trailer word.
  - The strobe for the last image word occurs in the first CHECK cycle.
  - Trailer == acc: go to RUN. Otherwise go to ERROR.
  - The trailer is never written to memory.
- RUN:
  - cpu_stall=0, done=1, s_ready=0, busy=0.
  - cpu_stall falls in the cycle after trailer acceptance.
  - start with a valid length: go to LOAD, cpu_stall=1, done=0 (reload).
  - start with an invalid length: go to ERROR.
- ERROR:
  - err=1, cpu_stall=1, done=0, s_ready=0.
  - start with a valid length: go to LOAD and clear err. An invalid length keeps ERROR.
- start in LOAD or CHECK is ignored.
- Bank/row mapping: word index i goes to bank i[9], row i[8:0]. This equals byte address 4*i, so bank = bit 11 and row = bits 10:2, consistent with fetch decoding.
- All outputs are registered.
- Throughput: 1 word/cycle. Latency from accept to strobe: 1 cycle.

Decomposition:
- Package imem_pkg:
  - State enum (IDLE, LOAD, CHECK, RUN, ERROR).
  - Constants IMEM_BANK_ROWS=512, IMEM_MAX_WORDS=1024, IMEM_BANK_SEL_BIT=11, IMEM_ROW_LSB=2, IMEM_ROW_MSB=10.
- Sub-module imem_wr_decode: word index to {we0, we1, waddr}, the registered write-port stage. The FSM stays in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> cpu_stall=1, s_ready=0, we0=we1=0, done=0, err=0, busy=0.
- Short image: start, load_len=3, words 0x11, 0x22, 0x33, trailer 0x66 -> we0 pulses at rows 0, 1, 2 with those data; we1 never high; cpu_stall=0 and done=1 one cycle after the trailer.
- Full image: load_len=1024, word i = i -> word 511 gives we0 row 511; word 512 gives we1 row 0; word 1023 gives we1 row 511; trailer 0x0007FE00 -> done=1.
- Bad checksum: load_len=2, words 1, 2, trailer 4 -> err=1, done=0, cpu_stall=1; then valid reload with 5, trailer 5 -> err=0, done=1.
- Illegal length: start with load_len=0 -> err=1 next cycle; start with load_len=1025 -> err=1; no write strobes in either case.
- Gaps and reset: load_len=4 with s_valid toggling 1,0,1,0 -> strobes only after accepts; rst_n=0 after word 2 -> no further strobes, state IDLE, cpu_stall=1.
